// File: rtl/aes_round_controller_if.sv
// ============================================================================
// Module   : aes_round_controller_if
// Purpose  : Plaintext/key input stream and ciphertext output stream of the
//            iterative AES-128 round controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_round_controller_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  // System side: produces blocks and consumes ciphertexts
  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  // Core side
  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext
  );
endinterface

`default_nettype wire

// File: rtl/aes_round_controller.sv
// ============================================================================
// Module   : aes_round_controller
// Purpose  : Control FSM and state register of the iterative AES-128 core.
//            Performs the initial AddRoundKey, sequences 10 rounds through an
//            external datapath using an external 4-bit round counter, and
//            presents the ciphertext on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_controller #(
  parameter int WD_LIMIT = 12
) (
  input  wire logic              clk,
  input  wire logic              rst,
  aes_round_controller_if.slave  bus,
  output logic [127:0]           round_in,
  input  wire logic [127:0]      round_out,
  output logic                   final_round,
  output logic                   cnt_enable,
  output logic                   cnt_clear,
  input  wire logic              overflow_flag,
  input  wire logic              print_ciphertext,
  output logic                   seq_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Last watchdog value tolerated in RUN before the sequence is declared stuck
  localparam logic [3:0] c_wd_last = 4'(WD_LIMIT - 1);

  state_e       state_q, state_d;
  logic [127:0] state_reg_q, state_reg_d;
  logic [3:0]   wd_q, wd_d;
  logic         seq_error_q, seq_error_d;
  logic         w_in_ready;
  logic         w_out_valid;

  // State, data and watchdog registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      state_reg_q <= '0;
      wd_q        <= '0;
      seq_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      state_reg_q <= state_reg_d;
      wd_q        <= wd_d;
      seq_error_q <= seq_error_d;
    end
  end

  // Next-state logic and counter/handshake controls
  always_comb begin
    state_d     = state_q;
    state_reg_d = state_reg_q;
    wd_d        = wd_q;
    seq_error_d = seq_error_q;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    cnt_enable  = 1'b0;
    cnt_clear   = 1'b0;
    final_round = 1'b0;

    case (state_q)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          // Initial AddRoundKey; the counter restarts from pc=0
          state_reg_d = bus.plaintext ^ bus.key;
          cnt_clear   = 1'b1;
          wd_d        = '0;
          state_d     = RUN;
        end
      end

      RUN: begin
        final_round = overflow_flag;
        state_reg_d = round_out;
        wd_d        = wd_q + 4'd1;
        if (overflow_flag) begin
          // Tenth round: counter steps to 10 and holds there in DONE
          cnt_enable = 1'b1;
          state_d    = DONE;
        end else if (wd_q == c_wd_last) begin
          // Counter never reached 9: abandon the block, keep the data
          seq_error_d = 1'b1;
          cnt_clear   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
        if (!print_ciphertext) begin
          seq_error_d = 1'b1;
        end
        if (bus.out_ready) begin
          cnt_clear = 1'b1;
          if (bus.in_valid) begin
            // Back-to-back: accept the next block in the handshake cycle
            state_reg_d = bus.plaintext ^ bus.key;
            wd_d        = '0;
            state_d     = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset zeroes the counter alongside the controller
    if (rst) begin
      cnt_clear  = 1'b1;
      cnt_enable = 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.ciphertext = w_out_valid ? state_reg_q : '0;
  assign round_in       = state_reg_q;
  assign seq_error      = seq_error_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_controller.sv
// ============================================================================
// Module   : tb_aes_round_controller
// Purpose  : Bench for aes_round_controller with a behavioural AES round
//            datapath and 4-bit round counter around it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] round_in;
  logic [127:0] round_out;
  logic         final_round;
  logic         cnt_enable;
  logic         cnt_clear;
  logic         overflow_flag;
  logic         print_ciphertext;
  logic         seq_error;

  logic [3:0]    pc = 4'd0;
  logic [1407:0] ks_q = '0;
  logic [3:0]    rk_sel;
  logic          force_ovf0 = 1'b0;
  logic          force_pc0  = 1'b0;

  int checks = 0;
  int errors = 0;
  int fr_cnt = 0;

  aes_round_controller_if bus ();

  aes_round_controller #(.WD_LIMIT(12)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .round_in         (round_in),
    .round_out        (round_out),
    .final_round      (final_round),
    .cnt_enable       (cnt_enable),
    .cnt_clear        (cnt_clear),
    .overflow_flag    (overflow_flag),
    .print_ciphertext (print_ciphertext),
    .seq_error        (seq_error)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural AES-128 helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] t = x;
    for (int i = 0; i < 7; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] ks;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      ks[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   c [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        c[r+4*cc] = b[r+4*((cc+r)%4)];
    if (!fin) begin
      for (int cc = 0; cc < 4; cc++) begin
        a0 = c[4*cc]; a1 = c[4*cc+1]; a2 = c[4*cc+2]; a3 = c[4*cc+3];
        c[4*cc]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        c[4*cc+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        c[4*cc+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        c[4*cc+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = c[i];
    return o ^ rk;
  endfunction

  // Round key schedule captured when a block is accepted
  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) ks_q <= expand(bus.key);
  end

  // Round counter: clear wins over enable
  always_ff @(posedge clk) begin
    if (cnt_clear)       pc <= 4'd0;
    else if (cnt_enable) pc <= pc + 4'd1;
  end

  assign overflow_flag    = (pc == 4'd9)  && !force_ovf0;
  assign print_ciphertext = (pc == 4'd10) && !force_pc0;

  // Combinational round datapath, round number pc+1
  always_comb begin
    rk_sel    = (pc < 4'd10) ? pc + 4'd1 : 4'd10;
    round_out = aes_round(round_in, ks_q[rk_sel*128 +: 128], final_round);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counter controls must never be asserted together
  always @(negedge clk) begin
    chk("clear_enable_exclusive", 128'(cnt_clear & cnt_enable), 128'(0));
    if (final_round) fr_cnt++;
  end

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  // Drive a block at an IDLE negedge; returns one negedge after the accept edge
  task automatic start_block(input int idx);
    chk("accept_ready", 128'(bus.in_ready), 128'(1));
    bus.plaintext = vecs[idx].pt;
    bus.key       = vecs[idx].key;
    bus.in_valid  = 1'b1;
    fr_cnt        = 0;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  // Additional negedges until out_valid, bounded
  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_full(input int idx);
    int n;
    bus.out_ready = 1'b1;
    start_block(idx);
    wait_out(n);
    chk("latency", 128'(n), 128'(10));
    chk("ciphertext", bus.ciphertext, vecs[idx].ct);
    chk("final_round_pulses", 128'(fr_cnt), 128'(1));
    chk("seq_error_clean", 128'(seq_error), 128'(0));
    chk("pc_done", 128'(pc), 128'(10));
    @(negedge clk);
    chk("out_valid_after_hs", 128'(bus.out_valid), 128'(0));
  endtask

  initial begin
    int n;
    int clr_k;
    logic [127:0] held;

    vecs[0] = '{128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734,
                128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    bus.in_valid  = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    bus.out_ready = 1'b0;

    // Reset
    @(negedge clk);
    @(negedge clk);
    chk("clear_during_rst", 128'(cnt_clear), 128'(1));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_ciphertext", bus.ciphertext, 128'(0));
    chk("rst_round_in", round_in, 128'(0));
    chk("rst_final_round", 128'(final_round), 128'(0));
    chk("rst_cnt_enable", 128'(cnt_enable), 128'(0));
    chk("rst_cnt_clear", 128'(cnt_clear), 128'(0));
    chk("rst_seq_error", 128'(seq_error), 128'(0));

    // Table of single blocks
    for (int i = 0; i < 3; i++) run_full(i);

    // Backpressure
    bus.out_ready = 1'b0;
    start_block(0);
    wait_out(n);
    chk("bp_latency", 128'(n), 128'(10));
    held = bus.ciphertext;
    chk("bp_ciphertext", held, vecs[0].ct);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
      chk("bp_ct_stable", bus.ciphertext, held);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
      chk("bp_pc_hold", 128'(pc), 128'(10));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 128'(bus.out_valid), 128'(0));

    // Back-to-back, three blocks
    bus.plaintext = vecs[0].pt;
    bus.key       = vecs[0].key;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wait_out(n);
      chk("b2b_interval", 128'(n), 128'(10));
      chk("b2b_ciphertext", bus.ciphertext, vecs[i].ct);
      chk("b2b_in_ready", 128'(bus.in_ready), 128'(1));
      if (i < 2) begin
        bus.plaintext = vecs[i+1].pt;
        bus.key       = vecs[i+1].key;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_idle", 128'(bus.in_ready), 128'(1));
    chk("b2b_out_valid", 128'(bus.out_valid), 128'(0));

    // Reset in the fifth RUN cycle
    start_block(1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_clear", 128'(cnt_clear), 128'(1));
    chk("midrst_enable", 128'(cnt_enable), 128'(0));
    chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst_round_in", round_in, 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pc", 128'(pc), 128'(0));
    chk("midrst_ciphertext", bus.ciphertext, 128'(0));
    chk("midrst_cnt_clear", 128'(cnt_clear), 128'(0));
    run_full(1);

    // Stuck counter: watchdog
    force_ovf0 = 1'b1;
    start_block(2);
    clr_k = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (cnt_clear && clr_k == 0) clr_k = k;
    end
    @(negedge clk);
    chk("wd_clear_cycle", 128'(clr_k), 128'(12));
    chk("wd_idle", 128'(bus.in_ready), 128'(1));
    chk("wd_seq_error", 128'(seq_error), 128'(1));
    chk("wd_no_output", 128'(bus.out_valid), 128'(0));
    force_ovf0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("seq_error_sticky", 128'(seq_error), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("seq_error_rst", 128'(seq_error), 128'(0));

    // print_ciphertext missing in DONE
    force_pc0     = 1'b1;
    bus.out_ready = 1'b0;
    start_block(0);
    wait_out(n);
    chk("pc0_latency", 128'(n), 128'(10));
    @(negedge clk);
    chk("pc0_seq_error", 128'(seq_error), 128'(1));
    chk("pc0_ciphertext", bus.ciphertext, vecs[0].ct);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("pc0_hs_done", 128'(bus.out_valid), 128'(0));
    chk("pc0_idle", 128'(bus.in_ready), 128'(1));
    force_pc0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
